// File: rtl/vga_capture_decoder_if.sv
// Video-in / framebuffer-write bundle for vga_capture_decoder.
// The master side is the video source (and framebuffer sink); the slave
// side is the decoder itself.
interface vga_capture_decoder_if;
  logic        iHS;
  logic        iVS;
  logic        iBLANK_n;
  logic [7:0]  iB_data;
  logic [7:0]  iG_data;
  logic [7:0]  iR_data;
  logic [18:0] oADDR;
  logic [23:0] oPIXEL;
  logic        oWR_EN;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic [9:0]  oH_ACTIVE;
  logic [9:0]  oV_ACTIVE;
  logic        oLOCKED;
  logic        oFRAME_DONE;

  modport master (
    output iHS, iVS, iBLANK_n, iB_data, iG_data, iR_data,
    input  oADDR, oPIXEL, oWR_EN, oX, oY, oH_ACTIVE, oV_ACTIVE, oLOCKED, oFRAME_DONE
  );

  modport slave (
    input  iHS, iVS, iBLANK_n, iB_data, iG_data, iR_data,
    output oADDR, oPIXEL, oWR_EN, oX, oY, oH_ACTIVE, oV_ACTIVE, oLOCKED, oFRAME_DONE
  );
endinterface

// File: rtl/vga_capture_decoder.sv
// vga_capture_decoder: samples a VGA-style stream, measures its active
// geometry, locks once two consecutive frames agree and then emits one
// framebuffer write per active pixel together with its coordinates.
module vga_capture_decoder #(
  parameter int FB_DEPTH = 307200
) (
  input logic                  iVGA_CLK,
  input logic                  iRST_n,
  vga_capture_decoder_if.slave vga
);
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [31:0] FB_DEPTH_U = 32'(FB_DEPTH);

  // 10-bit increment that sticks at full scale
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  logic        hs1_r, vs1_r, blank1_r, hs2_r, vs2_r;
  logic [23:0] pix1_r;
  logic [9:0]  cnt_x_r, cnt_y_r, cur_w_r, w_r, h_r;
  logic        bad_r;
  logic [18:0] addr_r;
  state_t      state_r, state_s;
  logic        done_r;
  logic        line_end_s, frame_end_s, capture_s;
  logic [9:0]  line_y_s, line_w_s;
  logic        line_bad_s, frame_good_s, frame_match_s, store_s, done_s;

  logic        wr_en_r, locked_r, frame_done_r;
  logic [23:0] pixel_r;
  logic [9:0]  x_r, y_r, h_act_r, v_act_r;
  logic [18:0] addr_out_r;

  assign line_end_s  = hs2_r & ~hs1_r;
  assign frame_end_s = vs2_r & ~vs1_r;
  assign capture_s   = blank1_r & (state_r == LOCKED);

  // Input sampling plus a second sync stage for fall detection
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs1_r    <= 1'b0;
      vs1_r    <= 1'b0;
      blank1_r <= 1'b0;
      pix1_r   <= 24'd0;
      hs2_r    <= 1'b0;
      vs2_r    <= 1'b0;
    end else begin
      hs1_r    <= vga.iHS;
      vs1_r    <= vga.iVS;
      blank1_r <= vga.iBLANK_n;
      pix1_r   <= {vga.iB_data, vga.iG_data, vga.iR_data};
      hs2_r    <= hs1_r;
      vs2_r    <= vs1_r;
    end
  end

  // Frame accumulators as they stand once any line closing this cycle is folded in,
  // so a coincident frame end sees the last line
  always_comb begin
    line_y_s   = cnt_y_r;
    line_w_s   = cur_w_r;
    line_bad_s = bad_r;
    if (blank1_r && !line_end_s && (cnt_x_r == 10'd1023)) begin
      line_bad_s = 1'b1;
    end else begin
      line_bad_s = bad_r;
    end
    if (line_end_s && (cnt_x_r != 10'd0)) begin
      line_y_s = sat_inc10(cnt_y_r);
      if (cnt_y_r == 10'd1023) begin
        line_bad_s = 1'b1;
      end else begin
        line_bad_s = line_bad_s;
      end
      if (cnt_y_r == 10'd0) begin
        line_w_s = cnt_x_r;
      end else if (cnt_x_r != cur_w_r) begin
        line_bad_s = 1'b1;
      end else begin
        line_w_s = cur_w_r;
      end
    end else begin
      line_y_s = cnt_y_r;
    end
  end

  assign frame_good_s  = ~line_bad_s & (line_y_s != 10'd0);
  assign frame_match_s = (line_w_s == w_r) & (line_y_s == h_r);

  // Lock FSM: next state, geometry store strobe and frame-done request
  always_comb begin
    state_s = state_r;
    store_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      SEARCH: begin
        if (frame_end_s) state_s = MEASURE;
        else             state_s = SEARCH;
      end
      MEASURE: begin
        if (frame_end_s && frame_good_s && frame_match_s) state_s = LOCKED;
        else if (frame_end_s)                             store_s = 1'b1;
        else                                              state_s = MEASURE;
      end
      LOCKED: begin
        if (frame_end_s && frame_good_s && frame_match_s) begin
          done_s = 1'b1;
        end else if (frame_end_s) begin
          state_s = MEASURE;
          store_s = 1'b1;
        end else begin
          state_s = LOCKED;
        end
      end
      default: state_s = SEARCH;
    endcase
  end

  // State, line/frame measurement and capture address
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r <= SEARCH;
      cnt_x_r <= 10'd0;
      cnt_y_r <= 10'd0;
      cur_w_r <= 10'd0;
      bad_r   <= 1'b0;
      w_r     <= 10'd0;
      h_r     <= 10'd0;
      addr_r  <= 19'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_s;
      if (line_end_s)    cnt_x_r <= 10'd0;
      else if (blank1_r) cnt_x_r <= sat_inc10(cnt_x_r);
      if (frame_end_s) begin
        cnt_y_r <= 10'd0;
        cur_w_r <= 10'd0;
        bad_r   <= 1'b0;
      end else begin
        cnt_y_r <= line_y_s;
        cur_w_r <= line_w_s;
        bad_r   <= line_bad_s;
      end
      // a bad frame leaves zeros so it can never be matched by the next one
      if (store_s) begin
        w_r <= frame_good_s ? line_w_s : 10'd0;
        h_r <= frame_good_s ? line_y_s : 10'd0;
      end
      if (frame_end_s)                           addr_r <= 19'd0;
      else if (blank1_r && addr_r != 19'h7FFFF)  addr_r <= addr_r + 19'd1;
    end
  end

  // Registered outputs: capture stream and lock status
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_en_r      <= 1'b0;
      pixel_r      <= 24'd0;
      x_r          <= 10'd0;
      y_r          <= 10'd0;
      addr_out_r   <= 19'd0;
      locked_r     <= 1'b0;
      h_act_r      <= 10'd0;
      v_act_r      <= 10'd0;
      frame_done_r <= 1'b0;
    end else begin
      wr_en_r <= capture_s & ({13'd0, addr_r} < FB_DEPTH_U);
      if (capture_s) begin
        pixel_r    <= pix1_r;
        x_r        <= cnt_x_r;
        y_r        <= cnt_y_r;
        addr_out_r <= addr_r;
      end
      locked_r     <= (state_r == LOCKED);
      h_act_r      <= (state_r == LOCKED) ? w_r : 10'd0;
      v_act_r      <= (state_r == LOCKED) ? h_r : 10'd0;
      frame_done_r <= done_r;
    end
  end

  assign vga.oWR_EN      = wr_en_r;
  assign vga.oPIXEL      = pixel_r;
  assign vga.oX          = x_r;
  assign vga.oY          = y_r;
  assign vga.oADDR       = addr_out_r;
  assign vga.oLOCKED     = locked_r;
  assign vga.oH_ACTIVE   = h_act_r;
  assign vga.oV_ACTIVE   = v_act_r;
  assign vga.oFRAME_DONE = frame_done_r;
endmodule

// File: tb/tb_vga_capture_decoder.sv
// Directed bench for vga_capture_decoder using small frame geometries and a
// reduced framebuffer depth so that every scenario stays short.
module tb_vga_capture_decoder;
  localparam int FB_D = 30;
  localparam int PIX_BASE = 24'h112233;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_capture_decoder_if vga();

  vga_capture_decoder #(.FB_DEPTH(FB_D)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .vga      (vga.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int  mon_w = 8;
  bit  vs_q = 1'b1;
  bit  lk_q = 1'b0;
  int  since_vs = 0;
  int  wr_cnt = 0, pix_err = 0, tot_wr = 0, viol = 0;
  int  first_addr = 0, first_x = 0, first_y = 0;
  int  last_addr = 0, last_x = 0, last_y = 0;
  int  fr_wr = 0, fr_pix_err = 0, fr_addr_end = 0;
  int  fr_first_addr = 0, fr_first_x = 0, fr_first_y = 0;
  int  fr_last_addr = 0, fr_last_x = 0, fr_last_y = 0;
  int  lock_lat = -1, done_lat = -1, done_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor: per-frame write statistics, latencies and invariant
  always @(negedge clk) begin
    if (!vga.iVS && vs_q) begin
      fr_wr = wr_cnt; fr_pix_err = pix_err; fr_addr_end = int'(vga.oADDR);
      fr_first_addr = first_addr; fr_first_x = first_x; fr_first_y = first_y;
      fr_last_addr = last_addr; fr_last_x = last_x; fr_last_y = last_y;
      wr_cnt = 0; pix_err = 0; since_vs = 0;
    end else begin
      since_vs = since_vs + 1;
    end
    vs_q = vga.iVS;
    if (vga.oLOCKED && !lk_q) lock_lat = since_vs;
    lk_q = vga.oLOCKED;
    if (vga.oFRAME_DONE) begin
      done_total++;
      done_lat = since_vs;
    end
    if (vga.oWR_EN) begin
      if (!vga.oLOCKED) viol++;
      if (int'(vga.oADDR) != wr_cnt || int'(vga.oX) != wr_cnt % mon_w ||
          int'(vga.oY) != wr_cnt / mon_w || vga.oPIXEL != 24'(PIX_BASE + wr_cnt))
        pix_err++;
      if (wr_cnt == 0) begin
        first_addr = int'(vga.oADDR); first_x = int'(vga.oX); first_y = int'(vga.oY);
      end
      last_addr = int'(vga.oADDR); last_x = int'(vga.oX); last_y = int'(vga.oY);
      wr_cnt++;
      tot_wr++;
    end
  end

  task automatic drive(input bit hs, input bit vs, input bit bl, input logic [23:0] c);
    @(posedge clk);
    #1;
    vga.iHS = hs;
    vga.iVS = vs;
    vga.iBLANK_n = bl;
    {vga.iB_data, vga.iG_data, vga.iR_data} = c;
  endtask

  // Vertical sync line; 'same' drops VS together with HS
  task automatic vsync_line(input bit same);
    drive(1'b0, same ? 1'b0 : 1'b1, 1'b0, 24'd0);
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 24'd0);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 24'd0);
  endtask

  // Active lines; row short_row carries one pixel fewer; trail adds a blank line
  task automatic body(input int w, input int h, input int short_row, input bit trail);
    int pix = 0;
    for (int r = 0; r < h; r++) begin
      repeat (2) drive(1'b0, 1'b1, 1'b0, 24'd0);
      repeat (2) drive(1'b1, 1'b1, 1'b0, 24'd0);
      for (int i = 0; i < ((r == short_row) ? w - 1 : w); i++) begin
        drive(1'b1, 1'b1, 1'b1, 24'(PIX_BASE + pix));
        pix++;
      end
      repeat (3) drive(1'b1, 1'b1, 1'b0, 24'd0);
    end
    if (trail) begin
      repeat (2) drive(1'b0, 1'b1, 1'b0, 24'd0);
      repeat (4) drive(1'b1, 1'b1, 1'b0, 24'd0);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vga.iHS = 1'b1; vga.iVS = 1'b1; vga.iBLANK_n = 1'b0;
    vga.iB_data = 8'd0; vga.iG_data = 8'd0; vga.iR_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", vga.oLOCKED, 0);
    check("rst_wr_en", vga.oWR_EN, 0);
    check("rst_addr", vga.oADDR, 0);
    check("rst_h_active", vga.oH_ACTIVE, 0);
    check("rst_pixel", vga.oPIXEL, 0);
    check("rst_frame_done", vga.oFRAME_DONE, 0);
    rst_n = 1'b1;

    // 8x3 stream: lock on the third VS fall
    mon_w = 8;
    vsync_line(1'b0);
    check("a_v1_locked", vga.oLOCKED, 0);
    body(8, 3, -1, 1'b1);
    vsync_line(1'b0);
    check("a_v2_locked", vga.oLOCKED, 0);
    check("a_v2_h_active", vga.oH_ACTIVE, 0);
    body(8, 3, -1, 1'b1);
    vsync_line(1'b0);
    check("a_v3_locked", vga.oLOCKED, 1);
    check("a_lock_latency", lock_lat, 3);
    check("a_h_active", vga.oH_ACTIVE, 8);
    check("a_v_active", vga.oV_ACTIVE, 3);
    check("a_writes_before_lock", tot_wr, 0);
    body(8, 3, -1, 1'b1);
    vsync_line(1'b0);
    check("a_frame_writes", fr_wr, 24);
    check("a_first_addr", fr_first_addr, 0);
    check("a_first_x", fr_first_x, 0);
    check("a_first_y", fr_first_y, 0);
    check("a_last_addr", fr_last_addr, 23);
    check("a_last_x", fr_last_x, 7);
    check("a_last_y", fr_last_y, 2);
    check("a_pixel_errors", fr_pix_err, 0);
    check("a_done_count", done_total, 1);
    check("a_done_latency", done_lat, 3);
    check("a_still_locked", vga.oLOCKED, 1);

    // one short line breaks lock; two clean frames relock
    body(8, 3, 1, 1'b1);
    vsync_line(1'b0);
    check("b_short_unlocked", vga.oLOCKED, 0);
    check("b_short_no_done", done_total, 1);
    check("b_short_writes", fr_wr, 23);
    body(8, 3, -1, 1'b1);
    vsync_line(1'b0);
    check("b_clean1_locked", vga.oLOCKED, 0);
    body(8, 3, -1, 1'b1);
    vsync_line(1'b0);
    check("b_relocked", vga.oLOCKED, 1);
    check("b_relock_h", vga.oH_ACTIVE, 8);

    // HS and VS falling together: the last active line still counts
    pulse_reset();
    check("c_after_reset_locked", vga.oLOCKED, 0);
    vsync_line(1'b1);
    body(8, 3, -1, 1'b0);
    vsync_line(1'b1);
    body(8, 3, -1, 1'b0);
    vsync_line(1'b1);
    check("c_same_edge_locked", vga.oLOCKED, 1);
    check("c_same_edge_h", vga.oH_ACTIVE, 8);
    check("c_same_edge_v", vga.oV_ACTIVE, 3);

    // 10x4 stream exceeds the framebuffer: writes stop at FB_D-1
    pulse_reset();
    mon_w = 10;
    vsync_line(1'b0);
    body(10, 4, -1, 1'b1);
    vsync_line(1'b0);
    body(10, 4, -1, 1'b1);
    vsync_line(1'b0);
    check("d_locked", vga.oLOCKED, 1);
    check("d_h_active", vga.oH_ACTIVE, 10);
    check("d_v_active", vga.oV_ACTIVE, 4);
    body(10, 4, -1, 1'b1);
    vsync_line(1'b0);
    check("d_frame_writes", fr_wr, 30);
    check("d_last_wr_addr", fr_last_addr, 29);
    check("d_last_x", fr_last_x, 9);
    check("d_last_y", fr_last_y, 2);
    check("d_addr_end", fr_addr_end, 39);
    check("d_pixel_errors", fr_pix_err, 0);

    // asynchronous reset mid-frame while locked
    body(10, 2, -1, 1'b0);
    check("e_pre_reset_locked", vga.oLOCKED, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("e_async_locked", vga.oLOCKED, 0);
    check("e_async_h_active", vga.oH_ACTIVE, 0);
    check("e_async_addr", vga.oADDR, 0);
    check("e_async_pixel", vga.oPIXEL, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    body(10, 2, -1, 1'b1);
    vsync_line(1'b0);
    check("e_partial_locked", vga.oLOCKED, 0);
    body(10, 4, -1, 1'b1);
    vsync_line(1'b0);
    check("e_full1_locked", vga.oLOCKED, 0);
    body(10, 4, -1, 1'b1);
    vsync_line(1'b0);
    check("e_full2_locked", vga.oLOCKED, 1);
    check("e_relock_v", vga.oV_ACTIVE, 4);

    check("wr_while_unlocked", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_capture_decoder.md
# vga_capture_decoder

Receive-side counterpart to the VGA timing/pixel output path. Samples an incoming VGA-style stream (active-low HS/VS, active-high blank_n, 8-bit B/G/R), measures its active geometry, locks once two consecutive frames agree, and then emits a framebuffer write stream (address, packed BGR pixel, write enable) plus pixel coordinates. Sits between a video source (or a loopback of our own VGA output) and a frame-buffer RAM.

## Interface
- FB_DEPTH, 307200, number of writable framebuffer words; writes at addresses >= FB_DEPTH are suppressed
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST_n  in  1  asynchronous, active-low reset
- iHS  in  1  horizontal sync, active low
- iVS  in  1  vertical sync, active low
- iBLANK_n  in  1  1 = active pixel
- iB_data, iG_data, iR_data  in  8 each  pixel colour
- oADDR  out  19  framebuffer write address
- oPIXEL  out  24  packed {B[23:16], G[15:8], R[7:0]}
- oWR_EN  out  1  write strobe, one cycle per captured pixel
- oX  out  10  column of the pixel on oPIXEL
- oY  out  10  row of the pixel on oPIXEL
- oH_ACTIVE  out  10  locked active width
- oV_ACTIVE  out  10  locked active height
- oLOCKED  out  1  geometry stable
- oFRAME_DONE  out  1  one-cycle pulse at end of each captured frame

## Operation
- Stage 1: all inputs registered (s1). Stage 2: s1 sync bits delayed (s2) for edge detection. Line end = s2_HS & !s1_HS (HS fall). Frame end = s2_VS & !s1_VS (VS fall).
- Line counter cnt_x (10 b, saturating at 1023) counts s1_BLANK_n-high cycles since last line end; cleared at line end. Saturation marks the frame bad.
- A closing line with cnt_x != 0 is an active line: cnt_y (10 b, saturating, saturation = bad) increments; the first active line of a frame latches cur_w = cnt_x; any later active line with cnt_x != cur_w marks the frame bad. Zero-count lines are ignored.
- Same-cycle HS fall and VS fall: the line closes first (counted and checked), then the frame is evaluated.
- Frame evaluation at frame end: frame good = not bad and cnt_y != 0. Then cnt_y, cur_w, bad cleared.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: at first frame end -> MEASURE (the partial frame is discarded, not evaluated).
  - MEASURE: at frame end, if good and (cur_w, cnt_y) == stored (W, H) -> LOCKED; otherwise store (cur_w, cnt_y) as (W, H) (store zeros if bad), stay.
  - LOCKED: at frame end, if good and matches (W, H): stay, pulse oFRAME_DONE; else -> MEASURE, store new values as above, no pulse.
- oH_ACTIVE/oV_ACTIVE = (W, H) while LOCKED, 0 otherwise. oLOCKED = (state == LOCKED).
- Capture (LOCKED only): for each s1_BLANK_n-high cycle, oWR_EN = 1 if addr < FB_DEPTH; oPIXEL = s1 colour; oX = cnt_x before increment; oY = active-line index; oADDR = addr; addr increments each active cycle (saturates at 2^19-1), cleared at frame end. Capture runs even in a frame that later fails evaluation.

## Timing
- Reset (async, iRST_n low): all registers 0, state SEARCH; all outputs 0 during and after reset until driven by activity.
- Latency: pin -> oWR_EN/oPIXEL/oADDR/oX/oY = 2 rising edges (s1 reg, output reg).
- oLOCKED, oH_ACTIVE, oV_ACTIVE, oFRAME_DONE update on the output edge following frame-end detection: 3 edges after the VS pin fall.
- First captured pixel after lock: oADDR = 0, oX = 0, oY = 0.
- Reset mid-frame: immediate return to SEARCH; relock needs the discarded partial frame plus two full matching frames.
- oWR_EN is never high while oLOCKED is low.

## Test plan
- 640x480@60 stream from our VGA timing generator, constant colour 0x112233 -> oLOCKED high 3 edges after 3rd VS fall; oH_ACTIVE = 640, oV_ACTIVE = 480; no writes before lock.
- Locked, incrementing pixel pattern -> exactly 307200 oWR_EN per frame, oADDR 0..307199, last write oX = 639, oY = 479; oFRAME_DONE one pulse per frame.
- Locked, one line shortened to 639 active pixels -> at that frame end oLOCKED falls, no oFRAME_DONE; relock after two further clean frames.
- 800x600 stream -> locks with 800/600; oWR_EN stops after oADDR 307199 while oADDR continues to 479999.
- HS and VS falling on the same cycle at frame start -> last active line counted, lock still achieved with 640/480.
- iRST_n low for 3 cycles mid-frame while locked -> all outputs 0 asynchronously; oLOCKED returns only after partial frame + 2 full frames.
